// File: rtl/img_proc_pkg.sv
// Shared definitions for the image pass controller.
// Holds the controller FSM state type and the default parameter values
// used by img_pass_ctrl and its sub-modules.
package img_proc_pkg;

    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_ADDR_W      = 6;
    localparam int unsigned DEF_NBUF        = 2;
    localparam int unsigned DEF_PASS_W      = 10;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } pass_state_e;

endpackage

// File: rtl/key_edge_det.sv
// Pushbutton synchroniser and press detector.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   key_n     - raw active-low pushbutton input (asynchronous)
//   press     - one-cycle pulse on each synchronised falling edge
// The synchroniser and edge-history flops reset to 1 (button released) so
// that leaving reset never looks like a press.
module key_edge_det
    import img_proc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = key_n;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign press = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/img_pass_ctrl.sv
// Multi-pass image filter controller.
// Sequences filter passes that ping-pong through NBUF result buffers: the
// first pass after a restart reads the source ROM, later passes read the
// buffer written by the previous pass.
// Ports:
//   clk, rst                 - system clock, async active-high reset
//   key, button              - active-low pushbuttons (run / restart+latch)
//   sw_kernel, sw_operator   - config switches, latched on restart
//   auto_mode, pass_target   - single step or run pass_target passes
//   flt_done, flt_wr_en      - filter pass-complete pulse and write strobe
//   flt_rd_addr, vga_addr    - filter and display read addresses
//   rom_data, ram_rd_data    - source ROM data and per-buffer read data
//   rd_addr                  - shared ROM/RAM read address
//   ram_wr_en                - one-hot buffer write enable
//   flt_rd_data, vga_data    - current source data to filter / display
//   flt_start, flt_abort     - one-cycle pass start / abort pulses
//   kernel_sel, operator_sel - latched configuration
//   pass_count, busy         - completed passes, pass in progress
module img_pass_ctrl
    import img_proc_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NBUF        = DEF_NBUF,
    parameter int unsigned PASS_W      = DEF_PASS_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key,
    input  logic                   button,
    input  logic                   sw_kernel,
    input  logic                   sw_operator,
    input  logic                   auto_mode,
    input  logic [PASS_W-1:0]      pass_target,
    input  logic                   flt_done,
    input  logic                   flt_wr_en,
    input  logic [ADDR_W-1:0]      flt_rd_addr,
    input  logic [ADDR_W-1:0]      vga_addr,
    input  logic [DATA_W-1:0]      rom_data,
    input  logic [NBUF*DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [NBUF-1:0]        ram_wr_en,
    output logic [DATA_W-1:0]      flt_rd_data,
    output logic [DATA_W-1:0]      vga_data,
    output logic                   flt_start,
    output logic                   flt_abort,
    output logic                   kernel_sel,
    output logic                   operator_sel,
    output logic [PASS_W-1:0]      pass_count,
    output logic                   busy
);

    localparam int unsigned        IDX_W    = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NBUF - 1);
    localparam logic [PASS_W-1:0]  PASS_MAX = '1;

    logic key_press;
    logic button_press;

    key_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_key_det (
        .clk   (clk),
        .rst   (rst),
        .key_n (key),
        .press (key_press)
    );

    key_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_button_det (
        .clk   (clk),
        .rst   (rst),
        .key_n (button),
        .press (button_press)
    );

    pass_state_e       state_q, state_d;
    logic [PASS_W-1:0] pass_count_q, pass_count_d;
    logic [PASS_W-1:0] remaining_q, remaining_d;
    logic [IDX_W-1:0]  src_idx_q, src_idx_d;
    logic [IDX_W-1:0]  dst_idx_q, dst_idx_d;
    logic              kernel_sel_q, kernel_sel_d;
    logic              operator_sel_q, operator_sel_d;

    logic [PASS_W-1:0] run_load;
    logic [PASS_W-1:0] pass_inc;
    logic [PASS_W-1:0] rem_dec;

    always_comb begin
        state_d        = state_q;
        pass_count_d   = pass_count_q;
        remaining_d    = remaining_q;
        src_idx_d      = src_idx_q;
        dst_idx_d      = dst_idx_q;
        kernel_sel_d   = kernel_sel_q;
        operator_sel_d = operator_sel_q;
        flt_abort      = 1'b0;

        run_load = auto_mode ? pass_target : PASS_W'(1);
        pass_inc = pass_count_q + PASS_W'(1);
        rem_dec  = remaining_q - PASS_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (button_press) begin
                    kernel_sel_d   = sw_kernel;
                    operator_sel_d = sw_operator;
                    pass_count_d   = '0;
                    src_idx_d      = '0;
                    dst_idx_d      = '0;
                end else if (key_press && (pass_count_q != PASS_MAX) &&
                             (run_load != '0)) begin
                    remaining_d = run_load;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flt_done) begin
                    pass_count_d = pass_inc;
                    // The buffer just written becomes the next source, so
                    // src always trails dst by one without any modulo.
                    src_idx_d    = dst_idx_q;
                    dst_idx_d    = (dst_idx_q == IDX_LAST) ? '0
                                                           : dst_idx_q + IDX_W'(1);
                    remaining_d  = rem_dec;
                    if ((rem_dec != '0) && (pass_inc != PASS_MAX)) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (button_press) begin
                    flt_abort = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pass_count_q   <= '0;
            remaining_q    <= '0;
            src_idx_q      <= '0;
            dst_idx_q      <= '0;
            kernel_sel_q   <= 1'b0;
            operator_sel_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pass_count_q   <= pass_count_d;
            remaining_q    <= remaining_d;
            src_idx_q      <= src_idx_d;
            dst_idx_q      <= dst_idx_d;
            kernel_sel_q   <= kernel_sel_d;
            operator_sel_q <= operator_sel_d;
        end
    end

    logic [DATA_W-1:0] src_data;

    always_comb begin
        src_data = rom_data;
        if (pass_count_q != '0) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                if (src_idx_q == IDX_W'(i)) begin
                    src_data = ram_rd_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        ram_wr_en = '0;
        if ((state_q == ST_RUN) && flt_wr_en) begin
            ram_wr_en[dst_idx_q] = 1'b1;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign flt_start    = (state_q == ST_START);
    assign rd_addr      = busy ? flt_rd_addr : vga_addr;
    assign flt_rd_data  = src_data;
    assign vga_data     = src_data;
    assign kernel_sel   = kernel_sel_q;
    assign operator_sel = operator_sel_q;
    assign pass_count   = pass_count_q;

endmodule

// File: tb/tb_img_pass_ctrl.sv
module tb_img_pass_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int NB   = 3;
    localparam int PW   = 3;
    localparam int PMAX = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              key = 1'b1;
    logic              button = 1'b1;
    logic              sw_kernel = 1'b0;
    logic              sw_operator = 1'b0;
    logic              auto_mode = 1'b0;
    logic [PW-1:0]     pass_target = '0;
    logic              flt_done = 1'b0;
    logic              flt_wr_en = 1'b0;
    logic [AW-1:0]     flt_rd_addr = '0;
    logic [AW-1:0]     vga_addr = '0;
    logic [DW-1:0]     rom_data = '0;
    logic [NB*DW-1:0]  ram_rd_data = '0;

    logic [AW-1:0]     rd_addr;
    logic [NB-1:0]     ram_wr_en;
    logic [DW-1:0]     flt_rd_data;
    logic [DW-1:0]     vga_data;
    logic              flt_start;
    logic              flt_abort;
    logic              kernel_sel;
    logic              operator_sel;
    logic [PW-1:0]     pass_count;
    logic              busy;

    img_pass_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .NBUF        (NB),
        .PASS_W      (PW),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .button       (button),
        .sw_kernel    (sw_kernel),
        .sw_operator  (sw_operator),
        .auto_mode    (auto_mode),
        .pass_target  (pass_target),
        .flt_done     (flt_done),
        .flt_wr_en    (flt_wr_en),
        .flt_rd_addr  (flt_rd_addr),
        .vga_addr     (vga_addr),
        .rom_data     (rom_data),
        .ram_rd_data  (ram_rd_data),
        .rd_addr      (rd_addr),
        .ram_wr_en    (ram_wr_en),
        .flt_rd_data  (flt_rd_data),
        .vga_data     (vga_data),
        .flt_start    (flt_start),
        .flt_abort    (flt_abort),
        .kernel_sel   (kernel_sel),
        .operator_sel (operator_sel),
        .pass_count   (pass_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int m_pc      = 0;     // model: completed passes since restart
    int start_cnt = 0;
    int abort_cnt = 0;
    logic [NB-1:0] first_we[$];

    always @(negedge clk) begin
        if (flt_start === 1'b1) start_cnt++;
        if (flt_abort === 1'b1) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of the source image: ROM before any pass, else the buffer that
    // holds the result of the most recent pass.
    function automatic logic [DW-1:0] exp_src();
        if (m_pc == 0) return rom_data;
        return ram_rd_data[((m_pc - 1) % NB) * DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        rom_data    = $urandom;
        ram_rd_data = {$urandom, $urandom, $urandom};
        vga_addr    = AW'($urandom);
        #1;
    endtask

    task automatic check_idle(input string tag);
        flt_wr_en = 1'b1;
        #1;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pc"}, pass_count, m_pc);
        chk({tag, "_rd_addr"}, rd_addr, vga_addr);
        chk({tag, "_vga"}, vga_data, exp_src());
        chk({tag, "_we"}, ram_wr_en, 0);
        flt_wr_en = 1'b0;
    endtask

    task automatic press_key(input bit expect_start);
        bit seen = 0;
        key = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (flt_start === 1'b1) seen = 1;
        end
        key = 1'b1;
        chk("key_start", seen, expect_start);
        if (seen) begin
            tick();
            chk("start_width", flt_start, 0);
            chk("busy_run", busy, 1);
        end else begin
            tick();
            chk("no_start_busy", busy, 0);
        end
    endtask

    task automatic press_button_idle();
        button = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        button = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic run_pass(input int ncyc);
        logic [NB-1:0] exp_we;
        for (int i = 0; i < ncyc; i++) begin
            flt_wr_en   = (i == 0) ? 1'b1 : 1'($urandom % 2);
            flt_rd_addr = AW'($urandom);
            #1;
            exp_we = flt_wr_en ? (NB'(1) << (m_pc % NB)) : '0;
            chk("rd_addr_run", rd_addr, flt_rd_addr);
            chk("wr_en_run", ram_wr_en, exp_we);
            chk("flt_rd_data", flt_rd_data, exp_src());
            if (i == 0) first_we.push_back(ram_wr_en);
            tick();
        end
        flt_wr_en = 1'b0;
        flt_done  = 1'b1;
        tick();
        flt_done  = 1'b0;
        m_pc++;
    endtask

    task automatic do_run(input int passes_req, input int len);
        int rem = passes_req;
        bit go  = (m_pc != PMAX) && (passes_req != 0);
        press_key(go);
        if (!go) return;
        while (rem > 0) begin
            run_pass(len + int'($urandom % 6));
            rem--;
            if (rem > 0 && m_pc != PMAX) begin
                chk("cont_start", flt_start, 1);
                tick();
            end else begin
                chk("end_busy", busy, 0);
                chk("end_start", flt_start, 0);
                rem = 0;
            end
        end
    endtask

    initial begin : main
        int s0;
        int a0;
        bit seen;
        logic [NB-1:0] exp_seq[5];

        // reset
        #1 rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_pc", pass_count, 0);
        chk("rst_kernel", kernel_sel, 0);
        chk("rst_operator", operator_sel, 0);
        chk("rst_start", flt_start, 0);
        chk("rst_abort", flt_abort, 0);
        chk("rst_we", ram_wr_en, 0);
        rst = 1'b0;
        tick(); tick();
        check_idle("post_rst");

        // single pass, 70 cycles; key held low through RUN must not restart
        auto_mode = 1'b0;
        first_we.delete();
        press_key(1);
        key = 1'b0;
        run_pass(70);
        key = 1'b1;
        chk("single_end_busy", busy, 0);
        chk("single_pc", pass_count, 1);
        chk("single_we0", first_we[0], 3'b001);
        chk("single_vga_slice0", vga_data, ram_rd_data[DW-1:0]);
        for (int i = 0; i < 4; i++) tick();
        chk("single_start_cnt", start_cnt, 1);
        check_idle("single");

        // flt_done outside RUN is ignored
        flt_done = 1'b1;
        tick();
        flt_done = 1'b0;
        tick();
        check_idle("done_idle");

        // restart with switches 1,1
        sw_kernel = 1'b1; sw_operator = 1'b1;
        press_button_idle();
        m_pc = 0;
        chk("restart_kernel", kernel_sel, 1);
        chk("restart_operator", operator_sel, 1);
        chk("restart_vga_rom", vga_data, rom_data);
        check_idle("restart");

        // auto mode, zero target: nothing happens
        auto_mode = 1'b1; pass_target = 3'd0;
        s0 = start_cnt;
        do_run(0, 3);
        chk("zero_target_starts", start_cnt - s0, 0);
        check_idle("zero_target");

        // auto mode, 5 passes through 3 buffers
        pass_target = 3'd5;
        first_we.delete();
        s0 = start_cnt;
        do_run(5, 4);
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        chk("auto5_starts", start_cnt - s0, 5);
        chk("auto5_nwr", first_we.size(), 5);
        for (int k = 0; k < 5 && k < first_we.size(); k++) begin
            chk($sformatf("auto5_dst%0d", k), first_we[k], exp_seq[k]);
        end
        check_idle("auto5");

        // abort during RUN: switches are not latched
        auto_mode = 1'b0;
        press_key(1);
        tick(); tick();
        sw_kernel = 1'b0; sw_operator = 1'b0;
        a0 = abort_cnt;
        button = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (flt_abort === 1'b1) seen = 1;
        end
        chk("abort_seen", seen, 1);
        chk("abort_pc", pass_count, m_pc);
        flt_wr_en = 1'b1;
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_we", ram_wr_en, 0);
        chk("abort_width", flt_abort, 0);
        flt_wr_en = 1'b0;
        button = 1'b1;
        tick(); tick(); tick();
        chk("abort_cnt", abort_cnt - a0, 1);
        chk("abort_kernel_kept", kernel_sel, 1);
        chk("abort_operator_kept", operator_sel, 1);
        check_idle("abort");

        // saturation at 7: auto run of 5 from 5 stops at 7
        auto_mode = 1'b1; pass_target = 3'd5;
        s0 = start_cnt;
        do_run(5, 3);
        chk("sat_starts", start_cnt - s0, 2);
        chk("sat_pc", pass_count, 7);
        auto_mode = 1'b0;
        s0 = start_cnt;
        do_run(1, 3);
        chk("sat_key_ignored", start_cnt - s0, 0);
        check_idle("sat");

        // restart latches new switches
        sw_kernel = 1'b0; sw_operator = 1'b1;
        press_button_idle();
        m_pc = 0;
        chk("restart2_kernel", kernel_sel, 0);
        chk("restart2_operator", operator_sel, 1);
        check_idle("restart2");

        // reset mid-RUN discards the pass silently
        press_key(1);
        tick(); tick();
        a0 = abort_cnt;
        flt_wr_en = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", ram_wr_en, 0);
        chk("midrst_pc", pass_count, 0);
        chk("midrst_operator", operator_sel, 0);
        flt_wr_en = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("midrst_no_abort", abort_cnt - a0, 0);
        check_idle("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/img_pass_ctrl.md
IMG_PASS_CTRL -- requirements
Module: img_pass_ctrl

Interface
REQ-001 Params SHALL be: DATA_W, default 64, pixel-row word width; ADDR_W, default 6, buffer address width; NBUF, default 2, result buffers (>=2); PASS_W, default 10, pass-counter width; SYNC_STAGES, default 2, input synchroniser depth.
REQ-002 One clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 Ports SHALL be, one per line:
  clk  in  1  system clock
  rst  in  1  async active-high reset
  key  in  1  active-low pushbutton: run pass(es)
  button  in  1  active-low pushbutton: latch config, restart from ROM
  sw_kernel  in  1  kernel select switch
  sw_operator  in  1  operator select switch
  auto_mode  in  1  0 = single step, 1 = run pass_target passes
  pass_target  in  PASS_W  passes per auto run
  flt_done  in  1  filter finished current pass (1-cycle pulse)
  flt_wr_en  in  1  filter write strobe
  flt_rd_addr  in  ADDR_W  filter read address
  vga_addr  in  ADDR_W  VGA read address
  rom_data  in  DATA_W  source image ROM data
  ram_rd_data  in  NBUF*DATA_W  buffer read data, buffer i at slice i
  rd_addr  out  ADDR_W  shared ROM/RAM read address
  ram_wr_en  out  NBUF  one-hot buffer write enable
  flt_rd_data  out  DATA_W  filter source data
  vga_data  out  DATA_W  display data
  flt_start  out  1  one-cycle pass start pulse
  flt_abort  out  1  one-cycle pass abort pulse
  kernel_sel  out  1  latched kernel select
  operator_sel  out  1  latched operator select
  pass_count  out  PASS_W  completed passes since restart
  busy  out  1  pass in progress

Function
REQ-004 key/button SHALL be synchronised (SYNC_STAGES flops) and press-detected on falling edge, one-cycle pulse per press.
REQ-005 FSM states: IDLE, START, RUN; START lasts exactly 1 cycle, asserts flt_start, goes to RUN.
REQ-006 IDLE + button press: latch sw_kernel/sw_operator into kernel_sel/operator_sel, pass_count<=0, src/dst indices reset; stay IDLE.
REQ-007 IDLE + key press: if pass_count at max (all ones) ignore; else load remaining<=(auto_mode ? pass_target : 1); if remaining would be 0, ignore; else go START.
REQ-008 Source: pass_count==0 -> rom_data; else buffer src_idx = (pass_count-1) mod NBUF. Destination dst_idx = pass_count mod NBUF. Both held as registered wrapping indices, no divider.
REQ-009 ram_wr_en SHALL be one-hot at dst_idx when state==RUN and flt_wr_en, else all zero.
REQ-010 rd_addr = flt_rd_addr when busy, else vga_addr; flt_rd_data and vga_data both = source data (combinational mux).
REQ-011 RUN + flt_done: pass_count+1, indices advance with wrap at NBUF-1->0, remaining-1; if remaining-1>0 and pass_count+1 not max -> START, else IDLE.
REQ-012 RUN + button press: flt_abort pulse, pass_count/indices unchanged, -> IDLE; switches not latched. flt_done same cycle: done wins, then abort ignored.
REQ-013 key during START/RUN ignored; flt_done outside RUN ignored.
REQ-014 busy = state != IDLE.

Reset
REQ-015 On rst: state IDLE, pass_count 0, src/dst indices 0, remaining 0, kernel_sel/operator_sel 0, flt_start/flt_abort 0, ram_wr_en 0, synchroniser flops 1 (released); rst mid-RUN discards pass with no flt_abort.

Structure
REQ-016 Package img_proc_pkg SHALL hold state enum and default parameter constants.
REQ-017 Sub-module key_edge_det (synchroniser + falling-edge pulse), instantiated for key and button.

Verification
REQ-018 Reset, key press, flt_done after 70 cycles -> flt_start 1 cycle, ram_wr_en=01 on writes, pass_count=1, vga_data=ram slice 0.
REQ-019 NBUF=3, auto_mode=1, pass_target=5 -> 5 flt_start pulses, dst sequence 0,1,2,0,1, pass_count=5, busy low after 5th done.
REQ-020 Button during RUN -> flt_abort pulse, pass_count unchanged, ram_wr_en 0, IDLE next cycle.
REQ-021 PASS_W=3, repeated steps -> pass_count saturates at 7; 8th key produces no flt_start.
REQ-022 auto_mode=1, pass_target=0 key -> no flt_start; button with switches 1,1 -> kernel_sel=operator_sel=1, pass_count=0, vga_data=rom_data.
